// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: the WIDTH-bit carry chain is cut into
// SEG-bit slices, one slice resolved per stage, with a global valid/ready stall.
`timescale 1ns/1ps

module pipelined_ripple_adder #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int L = WIDTH / SEG;

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] y_eff;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign y_eff    = sub ? ~y : y;

  // Bit-serial full-adder chain over one slice; returns {carry_out, sum}.
  function automatic logic [SEG:0] add_slice(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           ci);
    logic [SEG-1:0] sm;
    logic           c;
    c = ci;
    for (int i = 0; i < SEG; i++) begin
      sm[i] = a[i] ^ b[i] ^ c;
      c     = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, sm};
  endfunction

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int REM = WIDTH - (k + 1) * SEG;
    localparam int AW  = WIDTH - k * SEG;

    logic [AW-1:0]          a_in;
    logic [AW-1:0]          b_in;
    logic                   c_in;
    logic                   v_in;
    logic [SEG:0]           r;
    logic [(k+1)*SEG-1:0]   sum_nx;
    logic [(k+1)*SEG-1:0]   sum_p;
    logic                   cy_p;
    logic                   vld_p;

    if (k == 0) begin : g_src
      assign a_in   = x;
      assign b_in   = y_eff;
      assign c_in   = cin;
      assign v_in   = accept;
      assign sum_nx = r[SEG-1:0];
    end else begin : g_src
      assign a_in   = g_stage[k-1].g_fwd.x_p;
      assign b_in   = g_stage[k-1].g_fwd.y_p;
      assign c_in   = g_stage[k-1].cy_p;
      assign v_in   = g_stage[k-1].vld_p;
      assign sum_nx = {r[SEG-1:0], g_stage[k-1].sum_p};
    end

    assign r = add_slice(a_in[SEG-1:0], b_in[SEG-1:0], c_in);

    // ---- stage k register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
      end else if (advance) begin
        vld_p <= v_in;
      end
    end

    if (REM > 0) begin : g_fwd
      // Only the operand bits that later slices still need move forward.
      logic [REM-1:0] x_p;
      logic [REM-1:0] y_p;

      always_ff @(posedge clk) begin
        if (advance && v_in) begin
          x_p   <= a_in[AW-1:SEG];
          y_p   <= b_in[AW-1:SEG];
          sum_p <= sum_nx;
          cy_p  <= r[SEG];
        end
      end
    end else begin : g_last
      logic cmsb_p;

      // Output stage is cleared on reset so the result bus reads zero when idle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_p  <= '0;
          cy_p   <= 1'b0;
          cmsb_p <= 1'b0;
        end else if (advance && v_in) begin
          sum_p  <= sum_nx;
          cy_p   <= r[SEG];
          // Carry into the MSB recovered from its sum bit: c = s ^ a ^ b.
          cmsb_p <= a_in[SEG-1] ^ b_in[SEG-1] ^ r[SEG-1];
        end
      end
    end
  end

  assign out_valid = g_stage[L-1].vld_p;
  assign s         = g_stage[L-1].sum_p;
  assign cout      = g_stage[L-1].cy_p;
  assign ovf       = g_stage[L-1].g_last.cmsb_p ^ g_stage[L-1].cy_p;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder: four configurations checked against an
// arithmetic reference model through an in-order scoreboard.
`timescale 1ns/1ps

module tb_pipelined_ripple_adder;

  localparam int N     = 4;
  localparam int DEPTH = 4096;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  function automatic int w_of(input int i);
    return (i == 0) ? 8 : 32;
  endfunction

  function automatic int l_of(input int i);
    case (i)
      0:       return 2;
      1:       return 32;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] iv, ir, sub_d, cin_d, ov, ordy, co, of;
  logic [31:0]  x_d [N];
  logic [31:0]  y_d [N];
  logic [31:0]  s_o [N];
  logic [7:0]   s_w8;
  logic [31:0]  s_s1, s_s8, s_s32;

  int     cmp_cnt = 0;
  int     err_cnt = 0;
  longint edge_cnt = 0;
  bit     lat_mode = 1'b0;
  int     flush_req = 0;

  int     rd [N];
  int     wr [N];
  res_t   sb_res  [N][DEPTH];
  longint sb_edge [N][DEPTH];
  bit     sb_lat  [N][DEPTH];

  always #10 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always_comb begin
    s_o[0] = {24'h0, s_w8};
    s_o[1] = s_s1;
    s_o[2] = s_s8;
    s_o[3] = s_s32;
  end

  pipelined_ripple_adder #(.WIDTH(8), .SEG(4)) u_w8_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .x(x_d[0][7:0]), .y(y_d[0][7:0]), .cin(cin_d[0]), .sub(sub_d[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .s(s_w8), .cout(co[0]), .ovf(of[0]));

  pipelined_ripple_adder #(.WIDTH(32), .SEG(1)) u_w32_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .x(x_d[1]), .y(y_d[1]), .cin(cin_d[1]), .sub(sub_d[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .s(s_s1), .cout(co[1]), .ovf(of[1]));

  pipelined_ripple_adder #(.WIDTH(32), .SEG(8)) u_w32_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .x(x_d[2]), .y(y_d[2]), .cin(cin_d[2]), .sub(sub_d[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .s(s_s8), .cout(co[2]), .ovf(of[2]));

  pipelined_ripple_adder #(.WIDTH(32), .SEG(32)) u_w32_s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .x(x_d[3]), .y(y_d[3]), .cin(cin_d[3]), .sub(sub_d[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .s(s_s32), .cout(co[3]), .ovf(of[3]));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
    end
  endtask

  // Reference: modular sum for s/cout, true signed sum range test for ovf.
  function automatic res_t ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, input logic sb);
    res_t r;
    longint unsigned md, ua, ub, tot;
    longint sa, sbv, st;
    md  = 64'd1 << w;
    ua  = a & (md - 1);
    ub  = (sb ? ~b : b) & (md - 1);
    tot = ua + ub + longint'(ci);
    sa  = (ua >= md / 2) ? $signed(ua) - $signed(md) : $signed(ua);
    sbv = (ub >= md / 2) ? $signed(ub) - $signed(md) : $signed(ub);
    st  = sa + sbv + longint'(ci);
    r.s = 32'(tot & (md - 1));
    r.c = ((tot >> w) & 1) != 0;
    r.o = (st >= $signed(md / 2)) || (st < -$signed(md / 2));
    return r;
  endfunction

  // Compare process: checks every instance on every falling edge.
  initial begin : compare
    bit   seen [N];
    bit   stall_prev [N];
    res_t held [N];
    res_t e, got;
    int   flush_done, idx;
    flush_done = 0;
    for (int i = 0; i < N; i++) begin
      rd[i] = 0; wr[i] = 0; seen[i] = 0; stall_prev[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (flush_done != flush_req) begin
        flush_done = flush_req;
        for (int i = 0; i < N; i++) begin
          rd[i] = wr[i]; seen[i] = 0; stall_prev[i] = 0;
        end
      end
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          got.s = s_o[i]; got.c = co[i]; got.o = of[i];
          chk($sformatf("in_ready_rule[%0d]", i), ir[i], !ov[i] || ordy[i]);
          if (stall_prev[i]) begin
            chk($sformatf("stall_valid[%0d]", i), ov[i], 1);
            chk($sformatf("stall_hold[%0d]", i), got, held[i]);
          end
          if (ov[i]) begin
            if (rd[i] == wr[i]) begin
              chk($sformatf("spurious_out[%0d]", i), ov[i], 0);
            end else begin
              idx = rd[i] % DEPTH;
              e = sb_res[i][idx];
              chk($sformatf("s[%0d]", i), got.s, e.s);
              chk($sformatf("cout[%0d]", i), got.c, e.c);
              chk($sformatf("ovf[%0d]", i), got.o, e.o);
              if (!seen[i] && sb_lat[i][idx])
                chk($sformatf("latency[%0d]", i), edge_cnt - sb_edge[i][idx], l_of(i) - 1);
              seen[i] = 1;
              if (ordy[i]) begin
                rd[i]++;
                seen[i] = 0;
              end
            end
          end
          stall_prev[i] = ov[i] && !ordy[i];
          held[i] = got;
          if (iv[i] && ir[i]) begin
            idx = wr[i] % DEPTH;
            sb_res[i][idx]  = ref_op(w_of(i), x_d[i], y_d[i], cin_d[i], sub_d[i]);
            sb_edge[i][idx] = edge_cnt + 1;
            sb_lat[i][idx]  = lat_mode;
            wr[i]++;
          end
        end
      end
    end
  end

  task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic sb);
    @(posedge clk); #1;
    iv[0] = 1'b1; x_d[0] = a; y_d[0] = b; cin_d[0] = c; sub_d[0] = sb;
    @(posedge clk); #1;
    iv[0] = 1'b0; x_d[0] = $urandom; y_d[0] = $urandom;
    repeat (4) @(posedge clk);
  endtask

  task automatic pin(input string nm, input logic [31:0] a, input logic [31:0] b,
                     input logic c, input logic sb,
                     input logic [31:0] es, input logic ec, input logic eo);
    res_t r;
    r = ref_op(8, a, b, c, sb);
    chk({"model_", nm}, {r.s, r.c, r.o}, {es, ec, eo});
    send_one(a, b, c, sb);
  endtask

  task automatic run_stream(input logic [N-1:0] m, input int nb, input bit rr, input int vp);
    int cnt [N];
    bit acc [N];
    int guard;
    bit busy;
    for (int i = 0; i < N; i++) cnt[i] = m[i] ? 0 : nb;
    guard = 0;
    busy  = 1;
    while (busy && guard < 20000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) acc[i] = iv[i] && ir[i];
      @(posedge clk); #1;
      guard++;
      for (int i = 0; i < N; i++) begin
        if (m[i]) begin
          if (acc[i]) cnt[i]++;
          ordy[i] = rr ? ($urandom_range(0, 1) == 1) : 1'b1;
          if (acc[i] || !iv[i]) begin
            iv[i]    = (cnt[i] < nb) && ($urandom_range(0, 99) < vp);
            x_d[i]   = $urandom;
            y_d[i]   = $urandom;
            cin_d[i] = $urandom_range(0, 1) == 1;
            sub_d[i] = $urandom_range(0, 1) == 1;
          end
        end
      end
      busy = 0;
      for (int i = 0; i < N; i++) if (cnt[i] < nb) busy = 1;
    end
    chk("stream_complete", busy, 0);
    for (int i = 0; i < N; i++) if (m[i]) begin iv[i] = 1'b0; ordy[i] = 1'b1; end
  endtask

  task automatic wait_drain(input logic [N-1:0] m);
    int g;
    bit busy;
    g = 0;
    busy = 1;
    while (busy && g < 300) begin
      @(posedge clk); #1;
      g++;
      busy = 0;
      for (int i = 0; i < N; i++) if (m[i] && rd[i] != wr[i]) busy = 1;
    end
    chk("drain_complete", busy, 0);
  endtask

  task automatic reset_midflight();
    @(posedge clk); #1;
    iv[0] = 1'b1; x_d[0] = $urandom; y_d[0] = $urandom; cin_d[0] = 1'b1; sub_d[0] = 1'b0;
    @(posedge clk); #1;
    x_d[0] = $urandom; y_d[0] = $urandom;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", ov[0], 0);
    chk("midrst_s", s_o[0], 0);
    chk("midrst_cout", co[0], 0);
    chk("midrst_ovf", of[0], 0);
    flush_req++;
    #1 rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", ir[0], 1);
    repeat (8) begin
      @(negedge clk);
      chk("no_result_after_reset", ov[0], 0);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : main
    res_t r;
    iv = '0; ordy = '1; sub_d = '0; cin_d = '0;
    for (int i = 0; i < N; i++) begin x_d[i] = '0; y_d[i] = '0; end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset_valid[%0d]", i), ov[i], 0);
      chk($sformatf("reset_s[%0d]", i), s_o[i], 0);
      chk($sformatf("reset_cout[%0d]", i), co[i], 0);
      chk($sformatf("reset_ovf[%0d]", i), of[i], 0);
      chk($sformatf("reset_in_ready[%0d]", i), ir[i], 1);
    end

    lat_mode = 1'b1;
    pin("carry",      32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0);
    pin("ovf_pos",    32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1);
    pin("ovf_neg",    32'h80, 32'hFF, 1'b0, 1'b0, 32'h7F, 1'b1, 1'b1);
    pin("sub_neg",    32'h05, 32'h07, 1'b1, 1'b1, 32'hFE, 1'b0, 1'b0);
    pin("sub_pos",    32'h07, 32'h05, 1'b1, 1'b1, 32'h02, 1'b1, 1'b0);
    pin("sub_borrow", 32'h07, 32'h05, 1'b0, 1'b1, 32'h01, 1'b1, 1'b0);
    r = ref_op(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("model_carry32", {r.s, r.c, r.o}, {32'h0, 1'b1, 1'b0});
    r = ref_op(32, 32'h8000_0000, 32'h1, 1'b1, 1'b1);
    chk("model_sub32_ovf", {r.s, r.c, r.o}, {32'h7FFF_FFFF, 1'b1, 1'b1});
    wait_drain(4'b0001);

    lat_mode = 1'b0;
    run_stream(4'b0001, 16, 1'b1, 100);
    wait_drain(4'b0001);

    reset_midflight();

    lat_mode = 1'b1;
    run_stream(4'b1110, 1000, 1'b0, 70);
    wait_drain(4'b1110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

Parametrised, pipelined ripple-carry adder/subtractor, the next generation of the team's fixed 8-bit ripple adder. The WIDTH-bit carry chain is cut into SEG-bit slices. One slice resolves per clock, with operand and sum skew registers between slices. Throughput is one operation per cycle, with valid/ready handshakes on both sides. The block adds add/subtract mode and a signed-overflow flag, and it sits between operand producers and the datapath result bus.

## Interface
- WIDTH, default 8: operand and sum width. Must be a multiple of SEG.
- SEG, default 4: bits resolved per pipeline stage. SEG >= 1.
- Derived, not a port: L = WIDTH/SEG, the number of pipeline stages and the latency.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- cin  input  1  carry-in; in subtract mode this is the not-borrow-in.
- sub  input  1  mode: 0 computes x+y+cin; 1 computes x+~y+cin.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry out of bit WIDTH-1; in subtract mode this is the not-borrow.
- ovf  output  1  signed overflow, equal to carry-into-MSB XOR carry-out-of-MSB.

## Operation
- An input is accepted when in_valid && in_ready.
- On acceptance, stage 0 captures:
  - x and y_eff, where y_eff = sub ? ~y : y;
  - cin;
  - the stage-0 valid bit.
- Stage k (0..L-1) adds bits [k*SEG +: SEG] of x and y_eff with the carry registered from stage k-1 (or cin for k=0).
- Stage k registers its SEG sum bits and its carry out.
- Operand bits not yet consumed travel forward with the beat. Sum bits already produced travel forward with the beat.
- Within a slice, the carry ripples bit by bit as full-adder cells (xor/and/or). No lookahead.
- Final stage L-1 outputs:
  - s is the concatenated registered sum;
  - cout is the carry out of bit WIDTH-1;
  - ovf is the carry into bit WIDTH-1 XOR cout. The carry into bit WIDTH-1 is registered alongside cout.
- sub=1 with cin=1 gives plain two's-complement x-y. sub=1 with cin=0 gives x-y-1, which is used for borrow chaining.
- Arithmetic is modulo 2^WIDTH. No saturation.
- The pipeline stalls globally. advance = !out_valid || out_ready, and in_ready = advance (combinational).
- When advance=0, every stage register, including data and valid bits, holds.
- Bubbles are not collapsed.
- Each stage valid bit shifts on advance. Stage 0 valid loads (in_valid && in_ready).

## Timing
- Latency:
  - a beat accepted at edge n has out_valid=1 after edge n+L-1;
  - the result is visible in the cycle following edge n+L-1, at the earliest;
  - with SEG=WIDTH (L=1), the result is registered one cycle after acceptance.
- Throughput: one beat per cycle while out_ready=1.
- Back-pressure:
  - while out_valid && !out_ready, s, cout, ovf and out_valid are stable;
  - in_ready is 0 for the whole back-pressure period;
  - no beat is lost or duplicated.
- Simultaneous output drain and input accept in the same cycle is legal and required to work.
- Reset values:
  - all stage valid bits are 0, so out_valid=0;
  - s=0, cout=0, ovf=0;
  - in_ready=1 in the first cycle after rst_n deasserts.
- Reset mid-operation: assertion clears all beats in flight immediately (asynchronous). No partial result emerges after release.
- x, y, cin and sub are sampled only on acceptance. Changes on these inputs while in_ready=0 or in_valid=0 have no effect.

## Test plan
- Carry propagation, WIDTH=8 SEG=4: x=0xFF, y=0x01, cin=0, sub=0. Required: s=0x00, cout=1, ovf=0, out_valid rising 2 cycles after acceptance.
- Signed overflow: x=0x7F, y=0x01, sub=0. Required: s=0x80, cout=0, ovf=1. Also x=0x80, y=0xFF, sub=0. Required: s=0x7F, cout=1, ovf=1.
- Subtract: x=0x05, y=0x07, sub=1, cin=1. Required: s=0xFE, cout=0, ovf=0. Also x=0x07, y=0x05, sub=1, cin=1. Required: s=0x02, cout=1.
- Streaming and back-pressure: 16 back-to-back random beats with out_ready toggling pseudo-randomly. Required:
  - outputs match a reference model in order;
  - no drops or duplicates;
  - s, cout and ovf are stable during every stalled cycle;
  - in_ready equals !out_valid || out_ready every cycle.
- Reset mid-flight: accept 2 beats, then pulse rst_n low between clock edges. Required: out_valid=0 and s=0 immediately; no result emerges afterwards; in_ready=1 after release.
- Parameter sweep: WIDTH=32 with SEG in {1, 8, 32}, 1000 random beats each. Required: latency equals WIDTH/SEG and results are bit-exact against x+y+cin and x+~y+cin.
